systolic_result_drain: RTL

Downstream of the 4x4 systolic array with input memories. On the array's `done` rising edge, when `save_into_memory` is set, this block snapshots the 16 signed 16-bit results `r_00`..`r_33` and writes them one per cycle into a 256-entry result RAM starting at `base_addr`. The host reads results back through a registered read port. An optional accumulate mode supports K-tiled matrix products.

---
 rtl/systolic_result_drain_pkg.sv | 22 ++
 rtl/systolic_result_drain_result_ram.sv | 33 +++
 rtl/systolic_result_drain.sv | 127 ++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_pkg.sv
// Shared constants, drain FSM state type and saturating adder for the systolic result drain.
package sa_pkg;
  localparam int DATA_W = 16;
  localparam int N      = 4;
  localparam int ADDR_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  // Returns {overflow, clamped_sum}; clamps to the most positive/negative word.
  function automatic logic [DATA_W:0] sat_add16(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      return {1'b1, s[DATA_W], {(DATA_W-1){~s[DATA_W]}}};
    end
    return {1'b0, s[DATA_W-1:0]};
  endfunction
endpackage

// File: rtl/systolic_result_drain_result_ram.sv
// Result RAM: one write port, one asynchronous read port and one registered host read port.
module result_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] ara_i,
  output logic [DATA_W-1:0] ard_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  // Contents are deliberately not reset so results survive a block reset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Same-address read/write on one edge returns the old word.
  always_ff @(posedge clk) begin
    if (!rst) rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign ard_o     = mem_q[ara_i];
  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the NxN array results on a qualified done edge and writes them row-major into the result RAM.
// Optional feature macro DRAIN_ACCUM_EN: saturating accumulate onto the existing RAM contents.
module systolic_result_drain #(
  parameter int DATA_W = sa_pkg::DATA_W,
  parameter int N      = sa_pkg::N,
  parameter int ADDR_W = sa_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic                     save_into_memory,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [N*N*DATA_W-1:0]    r_flat,
`ifdef DRAIN_ACCUM_EN
  input  logic                     accumulate,
`endif
  input  logic                     clr_flags,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     wr_done,
  output logic                     dropped,
  output logic                     overflow
);
  import sa_pkg::*;

  localparam int NN    = N * N;
  localparam int IDX_W = $clog2(NN);

  drain_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     base_q;
  logic [NN*DATA_W-1:0]  snap_q;
  logic                  done_q, wr_done_q, dropped_q, overflow_q;
  logic                  trigger, in_write, last, we, ovf_set;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     snap_word, wdata, ram_ard;

  assign trigger   = done && !done_q && save_into_memory;
  assign in_write  = (state_q == WRITE);
  assign last      = in_write && (idx_q == IDX_W'(NN - 1));
  assign wr_addr   = base_q + ADDR_W'(idx_q);
  assign snap_word = snap_q[idx_q*DATA_W +: DATA_W];
  // A write on the reset edge is suppressed so an interrupted drain stops cleanly.
  assign we        = in_write && rst;

`ifdef DRAIN_ACCUM_EN
  logic              acc_q;
  logic [DATA_W:0]   acc_sum;
  assign acc_sum = sat_add16(ram_ard, snap_word);
  assign wdata   = acc_q ? acc_sum[DATA_W-1:0] : snap_word;
  assign ovf_set = we && acc_q && acc_sum[DATA_W];

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= 1'b0;
    else if (trigger && !in_write) acc_q <= accumulate;
  end
`else
  logic unused_ard;
  assign unused_ard = ^ram_ard;
  assign wdata      = snap_word;
  assign ovf_set    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      done_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      dropped_q  <= 1'b0;
      overflow_q <= 1'b0;
      base_q     <= '0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_q     <= done;
      wr_done_q  <= last;
      dropped_q  <= (trigger && in_write) || (dropped_q && !clr_flags);
      overflow_q <= ovf_set || (overflow_q && !clr_flags);
      if (trigger && !in_write) begin
        base_q <= base_addr;
        snap_q <= r_flat;
      end
    end
  end

  result_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .waddr_i   (wr_addr),
    .wdata_i   (wdata),
    .ara_i     (wr_addr),
    .ard_o     (ram_ard),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign busy     = in_write;
  assign wr_done  = wr_done_q;
  assign dropped  = dropped_q;
  assign overflow = overflow_q;
endmodule
